// File: rtl/img_stream_gen_if.sv
// Bundle for the RAM read port and the vsync/hsync/gray video stream of img_stream_gen.
// The master drives reads and video; the slave supplies RAM data and consumes video.
interface img_stream_gen_if #(
    parameter int ADDR_W = 18
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_data;
    logic              out_img_vsync;
    logic              out_img_hsync;
    logic [7:0]        out_img_gray;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output out_img_vsync,
        output out_img_hsync,
        output out_img_gray
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  out_img_vsync,
        input  out_img_hsync,
        input  out_img_gray
    );
endinterface

// File: rtl/img_stream_gen.sv
// Replays a stored grayscale frame from a 1-cycle-latency RAM as a vsync/hsync/gray stream.
// Defining IMG_GEN_PATTERN_EN adds a pattern_on input that replaces RAM data by a (row+col) ramp.
module img_stream_gen #(
    parameter int IMG_WIDTH  = 500,
    parameter int IMG_HEIGHT = 500,
    parameter int V_LEAD     = 10,
    parameter int H_BLANK    = 10,
    parameter int V_TAIL     = 1,
    parameter int ADDR_W     = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef IMG_GEN_PATTERN_EN
    input  logic             pattern_on,
`endif
    output logic             busy,
    output logic             frame_done,
    img_stream_gen_if.master bus
);
    localparam int CW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PMAX = (V_LEAD > H_BLANK) ? ((V_LEAD > V_TAIL) ? V_LEAD : V_TAIL)
                                             : ((H_BLANK > V_TAIL) ? H_BLANK : V_TAIL);
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    typedef enum logic [2:0] {IDLE, LEAD, ACTIVE, HBLANK, TAIL} state_t;

    state_t            state, next_state;
    logic [PW-1:0]     phase_cnt;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] rd_addr;
    logic              vsync_d, hsync_d;
    logic              start_ok, col_last, row_last;
    logic              timed_state;

    // A start is taken only once the previous frame has fully drained from the output stage.
    assign start_ok    = start && (state == IDLE) && !vsync_d;
    assign busy        = (state != IDLE) || vsync_d;
    assign col_last    = (col == CW'(IMG_WIDTH - 1));
    assign row_last    = (row == RW'(IMG_HEIGHT - 1));
    assign timed_state = (state == LEAD) || (state == HBLANK) || (state == TAIL);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ok) next_state = LEAD;
            LEAD:    if (phase_cnt == PW'(V_LEAD - 1)) next_state = ACTIVE;
            ACTIVE:  if (col_last) next_state = row_last ? TAIL : HBLANK;
            HBLANK:  if (phase_cnt == PW'(H_BLANK - 1)) next_state = ACTIVE;
            TAIL:    if (phase_cnt == PW'(V_TAIL - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The video flags are delayed one cycle so they line up with the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            col        <= '0;
            row        <= '0;
            rd_addr    <= '0;
            vsync_d    <= 1'b0;
            hsync_d    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state <= next_state;
            if (timed_state && (state == next_state))
                phase_cnt <= phase_cnt + PW'(1);
            else
                phase_cnt <= '0;
            if (start_ok) begin
                col     <= '0;
                row     <= '0;
                rd_addr <= '0;
            end else if (state == ACTIVE) begin
                rd_addr <= rd_addr + ADDR_W'(1);
                col     <= col_last ? '0 : col + CW'(1);
            end else if ((state == HBLANK) && (next_state == ACTIVE)) begin
                row <= row + RW'(1);
            end
            vsync_d    <= (state != IDLE);
            hsync_d    <= (state == ACTIVE);
            frame_done <= vsync_d && (state == IDLE);
        end
    end

`ifdef IMG_GEN_PATTERN_EN
    logic       pattern_hold;
    logic [7:0] pattern_pix;

    // The pattern choice is latched at start so a mid-frame change cannot tear the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_hold <= 1'b0;
            pattern_pix  <= 8'h00;
        end else begin
            if (start_ok)
                pattern_hold <= pattern_on;
            pattern_pix <= 8'(row) + 8'(col);
        end
    end

    assign bus.mem_rd_en    = (state == ACTIVE) && !pattern_hold;
    assign bus.out_img_gray = hsync_d ? (pattern_hold ? pattern_pix : bus.mem_rd_data) : 8'h00;
`else
    assign bus.mem_rd_en    = (state == ACTIVE);
    assign bus.out_img_gray = hsync_d ? bus.mem_rd_data : 8'h00;
`endif

    assign bus.mem_rd_addr   = rd_addr;
    assign bus.out_img_vsync = vsync_d;
    assign bus.out_img_hsync = hsync_d;
endmodule

// File: tb/tb_img_stream_gen.sv
// Scoreboard bench for img_stream_gen: a small 4x3 instance for framing/boundary cases
// and a 20x10 instance for pixel-for-pixel RAM replay.
module tb_img_stream_gen;
    localparam int A_W = 4, A_H = 3, A_VL = 2, A_HB = 3, A_VT = 1;
    localparam int A_VS_LEN = 21;
    localparam int B_W = 20, B_H = 10;
    localparam int B_VS_LEN = 301;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic busy_a, busy_b, fd_a, fd_b;
`ifdef IMG_GEN_PATTERN_EN
    logic pat_a = 1'b0;
    logic pat_b = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int frames_a = 0, frames_b = 0;

    logic [7:0] exp_pix_a[$];
    int         exp_vs_a[$];
    int         exp_rd_a[$];
    logic [7:0] exp_pix_b[$];

    logic [7:0] ram_a[16];
    logic [7:0] ram_b[256];

    img_stream_gen_if #(.ADDR_W(4)) bus_a ();
    img_stream_gen_if #(.ADDR_W(8)) bus_b ();

    img_stream_gen #(
        .IMG_WIDTH(A_W), .IMG_HEIGHT(A_H), .V_LEAD(A_VL),
        .H_BLANK(A_HB), .V_TAIL(A_VT), .ADDR_W(4)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
`ifdef IMG_GEN_PATTERN_EN
        .pattern_on(pat_a),
`endif
        .busy(busy_a), .frame_done(fd_a), .bus(bus_a)
    );

    img_stream_gen #(
        .IMG_WIDTH(B_W), .IMG_HEIGHT(B_H), .V_LEAD(10),
        .H_BLANK(10), .V_TAIL(1), .ADDR_W(8)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
`ifdef IMG_GEN_PATTERN_EN
        .pattern_on(pat_b),
`endif
        .busy(busy_b), .frame_done(fd_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_a.mem_rd_en) bus_a.mem_rd_data <= ram_a[bus_a.mem_rd_addr];
        if (bus_b.mem_rd_en) bus_b.mem_rd_data <= ram_b[bus_b.mem_rd_addr];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Issues a one-cycle start to instance A and queues the frame it should produce.
    task automatic applyStimulus(input bit pat);
        start_a = 1'b1;
        for (int r = 0; r < A_H; r++)
            for (int c = 0; c < A_W; c++)
                exp_pix_a.push_back(pat ? 8'(r + c) : 8'(r * A_W + c + 16));
        exp_vs_a.push_back(A_VS_LEN);
        exp_rd_a.push_back(pat ? 0 : A_W * A_H);
        @(posedge clk); #1;
        start_a = 1'b0;
        checkOutput("busy_after_start", busy_a, 1);
        checkOutput("vsync_low_after_edge0", bus_a.out_img_vsync, 0);
        @(posedge clk); #1;
        checkOutput("vsync_high_after_edge1", bus_a.out_img_vsync, 1);
    endtask

    task automatic waitFrameDone(input bit sel_b, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel_b ? fd_b : fd_a) && n < budget);
        if (!(sel_b ? fd_b : fd_a))
            checkOutput("frame_done_timeout", 0, 1);
        else
            checkOutput("busy_at_frame_done", sel_b ? busy_b : busy_a, 0);
    endtask

    // Monitor A: pops expected pixels on hsync and measures lead/blank/tail/line lengths.
    int  vs_len, hs_len, gap_len, line_cnt, rd_cnt;
    bit  vs_prev, hs_prev;
    always @(negedge clk) begin
        if (rst) begin
            vs_len = 0; hs_len = 0; gap_len = 0; line_cnt = 0; rd_cnt = 0;
            vs_prev = 1'b0; hs_prev = 1'b0;
        end else begin
            automatic bit vs = bus_a.out_img_vsync;
            automatic bit hs = bus_a.out_img_hsync;
            automatic bit fd_exp = vs_prev && !vs;
            if (bus_a.mem_rd_en) rd_cnt++;
            if (fd_a || fd_exp) checkOutput("frame_done_align", fd_a, fd_exp);
            if (fd_exp) begin
                frames_a++;
                if (exp_vs_a.size() == 0) begin
                    checkOutput("frame_unexpected", 1, 0);
                end else begin
                    checkOutput("vsync_len", vs_len, exp_vs_a.pop_front());
                    checkOutput("rd_en_count", rd_cnt, exp_rd_a.pop_front());
                    checkOutput("v_tail", gap_len, A_VT);
                    checkOutput("line_count", line_cnt, A_H);
                end
                vs_len = 0; gap_len = 0; line_cnt = 0; rd_cnt = 0;
            end
            if (hs) begin
                if (!vs) checkOutput("hsync_outside_vsync", 1, 0);
                if (!hs_prev) begin
                    if (line_cnt == 0) checkOutput("v_lead", gap_len, A_VL);
                    else               checkOutput("h_blank", gap_len, A_HB);
                    line_cnt++;
                    hs_len = 0;
                end
                hs_len++;
                gap_len = 0;
                if (exp_pix_a.size() == 0) checkOutput("pixel_unexpected", 1, 0);
                else checkOutput("gray", bus_a.out_img_gray, exp_pix_a.pop_front());
            end else begin
                if (hs_prev) checkOutput("line_len", hs_len, A_W);
                checkOutput("gray_zero_blank", bus_a.out_img_gray, 0);
                if (vs) gap_len++;
            end
            if (vs) vs_len++;
            vs_prev = vs;
            hs_prev = hs;
        end
    end

    // Monitor B: pixel-for-pixel replay check and frame length.
    int vs_len_b;
    bit vs_prev_b;
    always @(negedge clk) begin
        if (rst) begin
            vs_len_b = 0;
            vs_prev_b = 1'b0;
        end else begin
            if (bus_b.out_img_hsync) begin
                if (exp_pix_b.size() == 0) checkOutput("b_pixel_unexpected", 1, 0);
                else checkOutput("b_gray", bus_b.out_img_gray, exp_pix_b.pop_front());
            end
            if (vs_prev_b && !bus_b.out_img_vsync) begin
                frames_b++;
                checkOutput("b_vsync_len", vs_len_b, B_VS_LEN);
                checkOutput("b_frame_done_align", fd_b, 1);
                vs_len_b = 0;
            end
            if (bus_b.out_img_vsync) vs_len_b++;
            vs_prev_b = bus_b.out_img_vsync;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int frames_before;
        for (int i = 0; i < 16; i++) ram_a[i] = 8'(i + 16);
        for (int i = 0; i < 256; i++) ram_b[i] = 8'(i * 7 + 3);

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_vsync", bus_a.out_img_vsync, 0);
        checkOutput("rst_hsync", bus_a.out_img_hsync, 0);
        checkOutput("rst_gray", bus_a.out_img_gray, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_frame_done", fd_a, 0);
        checkOutput("rst_rd_en", bus_a.mem_rd_en, 0);
        checkOutput("rst_rd_addr", bus_a.mem_rd_addr, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] single frame");
        applyStimulus(1'b0);
        waitFrameDone(1'b0, 60);
        repeat (5) @(posedge clk);
        #1;

        $display("[TB] starts during a frame are ignored");
        frames_before = frames_a;
        applyStimulus(1'b0);
        for (int c = 2; c <= 23; c++) begin
            start_a = (c == 5 || c == 12 || c == 22);
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("ignored_start_frames", frames_a - frames_before, 1);

        $display("[TB] back-to-back frames");
        applyStimulus(1'b0);
        waitFrameDone(1'b0, 60);
        applyStimulus(1'b0);
        waitFrameDone(1'b0, 60);
        repeat (5) @(posedge clk);
        #1;

        $display("[TB] reset mid-frame at line 1 col 2");
        applyStimulus(1'b0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("mid_rd_en", bus_a.mem_rd_en, 1);
        checkOutput("mid_rd_addr", bus_a.mem_rd_addr, 6);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_vsync", bus_a.out_img_vsync, 0);
        checkOutput("abort_hsync", bus_a.out_img_hsync, 0);
        checkOutput("abort_gray", bus_a.out_img_gray, 0);
        checkOutput("abort_busy", busy_a, 0);
        checkOutput("abort_rd_en", bus_a.mem_rd_en, 0);
        checkOutput("abort_rd_addr", bus_a.mem_rd_addr, 0);
        exp_pix_a.delete();
        exp_vs_a.delete();
        exp_rd_a.delete();
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b0);
        waitFrameDone(1'b0, 60);
        repeat (5) @(posedge clk);
        #1;

`ifdef IMG_GEN_PATTERN_EN
        $display("[TB] pattern frame");
        pat_a = 1'b1;
        applyStimulus(1'b1);
        pat_a = 1'b0;
        waitFrameDone(1'b0, 60);
        repeat (5) @(posedge clk);
        #1;
`endif

        $display("[TB] 20x10 RAM replay");
        for (int i = 0; i < B_W * B_H; i++) exp_pix_b.push_back(8'(i * 7 + 3));
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        checkOutput("b_busy_after_start", busy_b, 1);
        waitFrameDone(1'b1, 400);
        repeat (10) @(posedge clk);
        #1;

        checkOutput("a_pixels_left", exp_pix_a.size(), 0);
        checkOutput("a_frames_left", exp_vs_a.size(), 0);
        checkOutput("b_pixels_left", exp_pix_b.size(), 0);
        checkOutput("b_frame_count", frames_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
